// File: rtl/hm_rx_if.sv
// hm_rx_if: PCIe TRN receive channel between the link core (master) and a receive engine (slave)
//   trn_rd[63:0]          receive data, [63:32] is the earlier dword
//   trn_rrem_n            0: only [63:32] valid on the EOF beat
//   trn_rsof_n/reof_n     start/end of TLP
//   trn_rsrc_rdy_n        source has a beat
//   trn_rsrc_dsc_n        source discontinue
//   trn_rerrfwd_n         poisoned TLP
//   trn_rdst_rdy_n        slave ready
//   trn_rnp_ok_n          non-posted flow control
//   trn_rcpl_streaming_n  completion streaming mode
interface hm_rx_if;
    logic [63:0] trn_rd;
    logic        trn_rrem_n;
    logic        trn_rsof_n;
    logic        trn_reof_n;
    logic        trn_rsrc_rdy_n;
    logic        trn_rsrc_dsc_n;
    logic        trn_rerrfwd_n;
    logic        trn_rdst_rdy_n;
    logic        trn_rnp_ok_n;
    logic        trn_rcpl_streaming_n;

    modport master (
        output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rerrfwd_n,
        input  trn_rdst_rdy_n, trn_rnp_ok_n, trn_rcpl_streaming_n
    );
    modport slave (
        input  trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rerrfwd_n,
        output trn_rdst_rdy_n, trn_rnp_ok_n, trn_rcpl_streaming_n
    );
endinterface

// File: rtl/hm_rx.sv
// hm_rx: consumes the CplD TLPs answering the 32-dword tag-0x38 host read and writes them to a 16x64 buffer
//   trn_clk, sys_rst      clock, synchronous active-high reset
//   trn                   TRN receive channel (hm_rx_if.slave)
//   rx_start              arm reception
//   rx_end/rx_error       one-cycle pulses: all 32 dwords written / bad completion
//   timeout               one-cycle pulse after 65535 cycles without a beat while armed
//   cfg_*                 own requester ID
//   hm_wr_en/addr/data    buffer write port, data = {dword 2k, dword 2k+1}
//   stat_*                completion/drop counters and current state
// Optional: define HM_RX_TIMEOUT_EN to build the timeout counter; otherwise timeout is tied 0.
module hm_rx (
    input  logic        trn_clk,
    input  logic        sys_rst,
    hm_rx_if.slave      trn,
    input  logic        rx_start,
    output logic        rx_end,
    output logic        rx_error,
    output logic        timeout,
    input  logic [7:0]  cfg_bus_number,
    input  logic [4:0]  cfg_device_number,
    input  logic [2:0]  cfg_function_number,
    output logic        hm_wr_en,
    output logic [3:0]  hm_wr_addr,
    output logic [63:0] hm_wr_data,
    output logic [31:0] stat_trn_cpt_rx,
    output logic [31:0] stat_trn_cpt_drop,
    output logic [1:0]  stat_state
);
    localparam logic [7:0] TAG = 8'h38;

    typedef enum logic [1:0] {IDLE, ARMED, DATA, DISCARD} state_t;

    state_t      state, ret, drop_to;
    logic        hdr, nodata, beat, sof, eof, is_cpl, mism, bad, drop;
    logic [2:0]  status;
    logic [9:0]  len;
    logic [31:0] held;
    logic [3:0]  wr_idx;
    logic [5:0]  dw_total;
`ifdef HM_RX_TIMEOUT_EN
    logic [15:0] to_cnt;
`endif

    assign trn.trn_rnp_ok_n         = 1'b0;
    assign trn.trn_rcpl_streaming_n = 1'b1;
    assign stat_state               = state;

    assign beat   = !trn.trn_rsrc_rdy_n && !trn.trn_rdst_rdy_n;
    assign sof    = !trn.trn_rsof_n;
    assign eof    = !trn.trn_reof_n;
    assign is_cpl = trn.trn_rd[60:56] == 5'b01010 && (trn.trn_rd[63:61] == 3'b010 || trn.trn_rd[63:61] == 3'b000);
    // DW2 sits in the upper half of the beat after the SOF beat
    assign mism   = trn.trn_rd[63:48] != {cfg_bus_number, cfg_device_number, cfg_function_number} ||
                    trn.trn_rd[47:40] != TAG;
    assign bad    = status != 3'b000 || nodata || trn.trn_rd[34] || len[0] || len == 10'd0 ||
                    11'(dw_total) + 11'(len) > 11'd32;
    // drop: this beat rejects the TLP it belongs to; drop_to is where we go once its EOF is seen
    assign drop    = beat && (state == IDLE || (state == ARMED && (hdr ? (mism || bad) : !(sof && is_cpl))));
    assign drop_to = state == IDLE ? (rx_start ? ARMED : IDLE) : (hdr && !mism ? IDLE : ARMED);

    always_ff @(posedge trn_clk) begin
        if (sys_rst) begin
            state              <= IDLE;
            ret                <= IDLE;
            hdr                <= 1'b0;
            nodata             <= 1'b0;
            status             <= '0;
            len                <= '0;
            held               <= '0;
            wr_idx             <= '0;
            dw_total           <= '0;
            trn.trn_rdst_rdy_n <= 1'b1;
            rx_end             <= 1'b0;
            rx_error           <= 1'b0;
            timeout            <= 1'b0;
            hm_wr_en           <= 1'b0;
            hm_wr_addr         <= '0;
            hm_wr_data         <= '0;
            stat_trn_cpt_rx    <= '0;
            stat_trn_cpt_drop  <= '0;
`ifdef HM_RX_TIMEOUT_EN
            to_cnt             <= '0;
`endif
        end else begin
            trn.trn_rdst_rdy_n <= 1'b0;
            rx_end             <= 1'b0;
            rx_error           <= 1'b0;
            timeout            <= 1'b0;
            hm_wr_en           <= 1'b0;
            if (state == IDLE && rx_start) begin
                state    <= ARMED;
                dw_total <= '0;
            end
            if (beat && state == ARMED) begin
                hdr <= !hdr && sof && is_cpl;
                if (!hdr) begin
                    nodata <= trn.trn_rd[63:61] == 3'b000;
                    status <= trn.trn_rd[15:13];
                    len    <= trn.trn_rd[41:32];
                end
                if (hdr && !mism && bad)
                    rx_error <= 1'b1;
                if (hdr && !drop) begin
                    held   <= trn.trn_rd[31:0];
                    wr_idx <= trn.trn_rd[38:35];
                    state  <= DATA;
                end
            end
            if (beat && state == DATA) begin
                // a trailing odd dword or overflow past 32 means the completion cannot be placed
                if (!trn.trn_rsrc_dsc_n || !trn.trn_rerrfwd_n || dw_total == 6'd32 || (eof && trn.trn_rrem_n)) begin
                    rx_error <= 1'b1;
                    state    <= IDLE;
                end else begin
                    hm_wr_en   <= 1'b1;
                    hm_wr_addr <= wr_idx;
                    hm_wr_data <= {held, trn.trn_rd[63:32]};
                    held       <= trn.trn_rd[31:0];
                    wr_idx     <= wr_idx + 4'd1;
                    dw_total   <= dw_total + 6'd2;
                    if (eof) begin
                        stat_trn_cpt_rx <= stat_trn_cpt_rx + 32'd1;
                        rx_end          <= dw_total == 6'd30;
                        state           <= dw_total == 6'd30 ? IDLE : ARMED;
                    end
                end
            end
            if (drop) begin
                ret   <= drop_to;
                state <= eof ? drop_to : DISCARD;
            end
            if (state == DISCARD && beat && eof)
                state <= ret;
            if ((drop || state == DISCARD) && beat && eof)
                stat_trn_cpt_drop <= stat_trn_cpt_drop + 32'd1;
`ifdef HM_RX_TIMEOUT_EN
            if ((state == ARMED || state == DATA) && !beat) begin
                to_cnt <= to_cnt + 16'd1;
                if (to_cnt == 16'hfffe) begin
                    timeout <= 1'b1;
                    state   <= IDLE;
                    hdr     <= 1'b0;
                end
            end else begin
                to_cnt <= '0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_hm_rx.sv
// tb_hm_rx: randomized self-checking bench for hm_rx against a dword-level placement model
`timescale 1ns/1ps
module tb_hm_rx;
    localparam logic [15:0] REQ_ID = {8'h5a, 5'h13, 3'h5};

    typedef struct packed {
        logic [63:0] d;
        logic        sof;
        logic        eof;
        logic        rrem_n;
    } beat_t;

    logic        trn_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        rx_start = 1'b0;
    logic        rx_end, rx_error, timeout, hm_wr_en;
    logic [3:0]  hm_wr_addr;
    logic [63:0] hm_wr_data;
    logic [31:0] stat_trn_cpt_rx, stat_trn_cpt_drop;
    logic [1:0]  stat_state;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, n_end = 0, n_err = 0, n_to = 0, end_cyc = 0;

    logic [3:0]  wa[$];
    logic [63:0] wd[$];
    int          wc[$];
    logic [3:0]  ea[$];
    logic [63:0] ed[$];
    logic [31:0] pl[$];
    beat_t       bq[$];
    int          bcyc[$];

    hm_rx_if trn();

    hm_rx dut (
        .trn_clk(trn_clk),
        .sys_rst(sys_rst),
        .trn(trn),
        .rx_start(rx_start),
        .rx_end(rx_end),
        .rx_error(rx_error),
        .timeout(timeout),
        .cfg_bus_number(8'h5a),
        .cfg_device_number(5'h13),
        .cfg_function_number(3'h5),
        .hm_wr_en(hm_wr_en),
        .hm_wr_addr(hm_wr_addr),
        .hm_wr_data(hm_wr_data),
        .stat_trn_cpt_rx(stat_trn_cpt_rx),
        .stat_trn_cpt_drop(stat_trn_cpt_drop),
        .stat_state(stat_state)
    );

    always #5 trn_clk = ~trn_clk;
    always @(posedge trn_clk) cyc <= cyc + 1;

    always @(negedge trn_clk) begin
        if (hm_wr_en === 1'b1) begin
            wa.push_back(hm_wr_addr);
            wd.push_back(hm_wr_data);
            wc.push_back(cyc);
        end
        if (rx_end === 1'b1) begin
            n_end++;
            end_cyc = cyc;
        end
        if (rx_error === 1'b1) n_err++;
        if (timeout === 1'b1) n_to++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge trn_clk);
        #1;
    endtask

    task automatic arm();
        rx_start = 1'b1;
        @(posedge trn_clk);
        #1;
        rx_start = 1'b0;
    endtask

    // header DW0..DW2 followed by the payload queue, packed two dwords per beat
    task automatic build(input logic [2:0] fmt, input logic [2:0] st, input logic [7:0] tag,
                         input logic [6:0] la, input int len);
        logic [31:0] dw[$];
        int n;
        beat_t b;
        dw = {};
        dw.push_back({fmt, 5'b01010, 14'd0, 10'(len)});
        dw.push_back({16'hbeef, st, 1'b0, 12'(len * 4)});
        dw.push_back({REQ_ID, tag, 1'b0, la});
        foreach (pl[i]) dw.push_back(pl[i]);
        n = (dw.size() + 1) / 2;
        bq = {};
        for (int i = 0; i < n; i++) begin
            b.d      = {dw[2*i], (2*i+1 < dw.size()) ? dw[2*i+1] : 32'h0};
            b.sof    = i == 0;
            b.eof    = i == n - 1;
            b.rrem_n = !(i == n - 1 && 2*i+1 >= dw.size());
            bq.push_back(b);
        end
    endtask

    // expected buffer writes: dword j of a completion lands at dword address la/4 + j
    task automatic model(input logic [6:0] la);
        logic [3:0] base;
        base = la[6:3];
        for (int k = 0; k < pl.size() / 2; k++) begin
            ea.push_back(base + 4'(k));
            ed.push_back({pl[2*k], pl[2*k+1]});
        end
    endtask

    task automatic put_beat(input beat_t b, output logic acc);
        trn.trn_rd         = b.d;
        trn.trn_rsof_n     = !b.sof;
        trn.trn_reof_n     = !b.eof;
        trn.trn_rrem_n     = b.rrem_n;
        trn.trn_rsrc_rdy_n = 1'b0;
        acc = trn.trn_rdst_rdy_n === 1'b0 && !sys_rst;
        @(posedge trn_clk);
        #1;
        trn.trn_rsrc_rdy_n = 1'b1;
        trn.trn_rsof_n     = 1'b1;
        trn.trn_reof_n     = 1'b1;
    endtask

    task automatic send_range(input int first, input bit gaps);
        logic acc;
        int tries;
        for (int i = first; i < bq.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            tries = 0;
            do begin
                put_beat(bq[i], acc);
                tries++;
            end while (!acc && tries < 20);
            if (!acc) begin
                n_chk++;
                $display("FAIL beat_accept: beat %0d not accepted within %0d cycles", i, tries);
            end
            bcyc.push_back(cyc);
        end
    endtask

    task automatic clear_q();
        wa = {}; wd = {}; wc = {}; ea = {}; ed = {}; bcyc = {};
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(posedge trn_clk);
        #1;
        n_chk++;
        if ({rx_end, rx_error, timeout, hm_wr_en, hm_wr_addr, hm_wr_data, stat_trn_cpt_rx, stat_trn_cpt_drop, stat_state} !== '0)
            $display("FAIL reset_outputs: end=%b err=%b to=%b wr=%b addr=%h data=%h rx=%0d drop=%0d st=%0d, required all 0",
                     rx_end, rx_error, timeout, hm_wr_en, hm_wr_addr, hm_wr_data, stat_trn_cpt_rx, stat_trn_cpt_drop, stat_state);
        else n_pass++;
        n_chk++;
        if (trn.trn_rdst_rdy_n !== 1'b1) $display("FAIL reset_rdst_rdy: got %b required 1", trn.trn_rdst_rdy_n);
        else n_pass++;
        n_chk++;
        if (trn.trn_rcpl_streaming_n !== 1'b1) $display("FAIL reset_cpl_streaming: got %b required 1", trn.trn_rcpl_streaming_n);
        else n_pass++;
        n_chk++;
        if (trn.trn_rnp_ok_n !== 1'b0) $display("FAIL reset_np_ok: got %b required 0", trn.trn_rnp_ok_n);
        else n_pass++;
        sys_rst = 1'b0;
        idle(1);
        n_chk++;
        if (trn.trn_rdst_rdy_n !== 1'b0) $display("FAIL post_reset_rdst_rdy: got %b required 0", trn.trn_rdst_rdy_n);
        else n_pass++;
    endtask

    task automatic test_single();
        int e0;
        e0 = n_end;
        clear_q();
        arm();
        n_chk++;
        if (stat_state !== 2'd1) $display("FAIL single_armed: state %0d required 1", stat_state);
        else n_pass++;
        pl = {};
        for (int i = 0; i < 32; i++) pl.push_back(32'h1000 + 32'(i));
        build(3'b010, 3'b000, 8'h38, 7'h00, 32);
        model(7'h00);
        send_range(0, 1'b0);
        idle(4);
        n_chk++;
        if (wa.size() != 16) $display("FAIL single_nwr: got %0d writes required 16", wa.size());
        else n_pass++;
        for (int k = 0; k < ea.size(); k++) begin
            n_chk++;
            if (k >= wa.size() || wa[k] !== ea[k] || wd[k] !== ed[k])
                $display("FAIL single_wr%0d: got addr %h data %h required addr %h data %h", k,
                         k < wa.size() ? wa[k] : 4'hx, k < wd.size() ? wd[k] : 64'hx, ea[k], ed[k]);
            else n_pass++;
        end
        n_chk++;
        if (wc.size() == 0 || bcyc.size() < 3 || wc[0] != bcyc[2])
            $display("FAIL single_latency: first write cycle %0d required %0d", wc.size() ? wc[0] : -1, bcyc.size() > 2 ? bcyc[2] : -1);
        else n_pass++;
        n_chk++;
        if (n_end - e0 != 1 || wc.size() == 0 || end_cyc != wc[wc.size()-1])
            $display("FAIL single_rx_end: %0d pulses at cycle %0d, required 1 with last write", n_end - e0, end_cyc);
        else n_pass++;
        n_chk++;
        if (stat_trn_cpt_rx !== 32'd1) $display("FAIL single_cpt_rx: got %0d required 1", stat_trn_cpt_rx);
        else n_pass++;
        n_chk++;
        if (stat_state !== 2'd0) $display("FAIL single_idle: state %0d required 0", stat_state);
        else n_pass++;
    endtask

    task automatic test_split();
        int e0;
        logic [31:0] r0;
        e0 = n_end;
        r0 = stat_trn_cpt_rx;
        clear_q();
        arm();
        pl = {};
        for (int i = 0; i < 16; i++) pl.push_back($urandom);
        build(3'b010, 3'b000, 8'h38, 7'h00, 16);
        model(7'h00);
        send_range(0, 1'b1);
        idle(3);
        n_chk++;
        if (stat_state !== 2'd1 || n_end != e0)
            $display("FAIL split_mid: state %0d rx_end %0d, required state 1 and no rx_end", stat_state, n_end - e0);
        else n_pass++;
        pl = {};
        for (int i = 0; i < 16; i++) pl.push_back($urandom);
        build(3'b010, 3'b000, 8'h38, 7'h40, 16);
        model(7'h40);
        send_range(0, 1'b1);
        idle(4);
        n_chk++;
        if (wa.size() != 16) $display("FAIL split_nwr: got %0d writes required 16", wa.size());
        else n_pass++;
        for (int k = 0; k < ea.size(); k++) begin
            n_chk++;
            if (k >= wa.size() || wa[k] !== ea[k] || wd[k] !== ed[k])
                $display("FAIL split_wr%0d: got addr %h data %h required addr %h data %h", k,
                         k < wa.size() ? wa[k] : 4'hx, k < wd.size() ? wd[k] : 64'hx, ea[k], ed[k]);
            else n_pass++;
        end
        n_chk++;
        if (n_end - e0 != 1 || stat_trn_cpt_rx - r0 != 32'd2)
            $display("FAIL split_done: rx_end %0d cpt_rx +%0d, required 1 and +2", n_end - e0, stat_trn_cpt_rx - r0);
        else n_pass++;
    endtask

    task automatic test_mismatch();
        int e0;
        logic [31:0] d0;
        e0 = n_end;
        d0 = stat_trn_cpt_drop;
        clear_q();
        arm();
        pl = {};
        for (int i = 0; i < 32; i++) pl.push_back($urandom);
        build(3'b010, 3'b000, 8'h37, 7'h00, 32);
        send_range(0, 1'b1);
        pl = {};
        for (int i = 0; i < 32; i++) pl.push_back($urandom);
        build(3'b010, 3'b000, 8'h38, 7'h00, 32);
        model(7'h00);
        send_range(0, 1'b1);
        idle(4);
        n_chk++;
        if (wa.size() != 16) $display("FAIL mismatch_nwr: got %0d writes required 16", wa.size());
        else n_pass++;
        for (int k = 0; k < ea.size(); k++) begin
            n_chk++;
            if (k >= wa.size() || wa[k] !== ea[k] || wd[k] !== ed[k])
                $display("FAIL mismatch_wr%0d: got addr %h data %h required addr %h data %h", k,
                         k < wa.size() ? wa[k] : 4'hx, k < wd.size() ? wd[k] : 64'hx, ea[k], ed[k]);
            else n_pass++;
        end
        n_chk++;
        if (stat_trn_cpt_drop - d0 != 32'd1) $display("FAIL mismatch_drop: got +%0d required +1", stat_trn_cpt_drop - d0);
        else n_pass++;
        n_chk++;
        if (n_end - e0 != 1) $display("FAIL mismatch_rx_end: got %0d pulses required 1", n_end - e0);
        else n_pass++;
    endtask

    task automatic test_idle_consume();
        logic [31:0] d0;
        d0 = stat_trn_cpt_drop;
        clear_q();
        pl = {};
        for (int i = 0; i < 8; i++) pl.push_back($urandom);
        build(3'b010, 3'b000, 8'h38, 7'h00, 8);
        send_range(0, 1'b1);
        idle(3);
        n_chk++;
        if (wa.size() != 0 || stat_state !== 2'd0 || stat_trn_cpt_drop - d0 != 32'd1)
            $display("FAIL idle_consume: writes %0d state %0d drop +%0d, required 0, 0, +1", wa.size(), stat_state, stat_trn_cpt_drop - d0);
        else n_pass++;
    endtask

    task automatic test_error();
        int r0;
        for (int c = 0; c < 3; c++) begin
            r0 = n_err;
            clear_q();
            arm();
            pl = {};
            if (c == 0) build(3'b000, 3'b001, 8'h38, 7'h00, 0);
            if (c == 1) begin
                for (int i = 0; i < 3; i++) pl.push_back($urandom);
                build(3'b010, 3'b000, 8'h38, 7'h00, 3);
            end
            if (c == 2) begin
                for (int i = 0; i < 8; i++) pl.push_back($urandom);
                build(3'b010, 3'b000, 8'h38, 7'h04, 8);
            end
            send_range(0, 1'b1);
            idle(3);
            n_chk++;
            if (n_err - r0 != 1) $display("FAIL error%0d_pulse: got %0d rx_error pulses required 1", c, n_err - r0);
            else n_pass++;
            n_chk++;
            if (wa.size() != 0) $display("FAIL error%0d_nwr: got %0d writes required 0", c, wa.size());
            else n_pass++;
            n_chk++;
            if (stat_state !== 2'd0) $display("FAIL error%0d_state: got %0d required 0", c, stat_state);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        e0 = n_end;
        clear_q();
        arm();
        pl = {};
        for (int i = 0; i < 32; i++) pl.push_back($urandom);
        build(3'b010, 3'b000, 8'h38, 7'h00, 32);
        bq = bq[0:3];
        send_range(0, 1'b0);
        build(3'b010, 3'b000, 8'h38, 7'h00, 32);
        trn.trn_rd         = bq[4].d;
        trn.trn_rsof_n     = 1'b1;
        trn.trn_reof_n     = 1'b1;
        trn.trn_rsrc_rdy_n = 1'b0;
        sys_rst            = 1'b1;
        @(posedge trn_clk);
        #1;
        n_chk++;
        if (trn.trn_rdst_rdy_n !== 1'b1) $display("FAIL midrst_rdst_rdy: got %b required 1", trn.trn_rdst_rdy_n);
        else n_pass++;
        n_chk++;
        if ({rx_end, rx_error, timeout, hm_wr_en, hm_wr_addr, hm_wr_data, stat_trn_cpt_rx, stat_trn_cpt_drop, stat_state} !== '0)
            $display("FAIL midrst_outputs: wr=%b rx=%0d drop=%0d st=%0d, required all 0", hm_wr_en, stat_trn_cpt_rx, stat_trn_cpt_drop, stat_state);
        else n_pass++;
        sys_rst = 1'b0;
        trn.trn_rsrc_rdy_n = 1'b1;
        send_range(4, 1'b0);
        idle(4);
        n_chk++;
        if (stat_trn_cpt_drop !== 32'd1 || stat_trn_cpt_rx !== 32'd0)
            $display("FAIL midrst_tail: drop %0d cpt_rx %0d, required 1 and 0", stat_trn_cpt_drop, stat_trn_cpt_rx);
        else n_pass++;
        n_chk++;
        if (wa.size() != 2 || stat_state !== 2'd0 || n_end != e0)
            $display("FAIL midrst_writes: writes %0d state %0d rx_end %0d, required 2, 0, 0", wa.size(), stat_state, n_end - e0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int i;
        i = 0;
        arm();
`ifdef HM_RX_TIMEOUT_EN
        while (timeout !== 1'b1 && i < 70000) begin
            @(posedge trn_clk);
            #1;
            i++;
        end
        n_chk++;
        if (i != 65535) $display("FAIL timeout_cycle: pulse after %0d cycles required 65535", i);
        else n_pass++;
        n_chk++;
        if (stat_state !== 2'd0) $display("FAIL timeout_state: got %0d required 0", stat_state);
        else n_pass++;
        idle(1);
        n_chk++;
        if (timeout !== 1'b0 || n_to != 1) $display("FAIL timeout_pulse: level %b pulses %0d, required 0 and 1", timeout, n_to);
        else n_pass++;
`else
        while (i < 65600) begin
            @(posedge trn_clk);
            #1;
            i++;
        end
        n_chk++;
        if (n_to != 0 || timeout !== 1'b0) $display("FAIL timeout_disabled: pulses %0d required 0", n_to);
        else n_pass++;
        n_chk++;
        if (stat_state !== 2'd1) $display("FAIL timeout_disabled_state: got %0d required 1", stat_state);
        else n_pass++;
`endif
    endtask

    initial begin
        trn.trn_rd         = '0;
        trn.trn_rrem_n     = 1'b1;
        trn.trn_rsof_n     = 1'b1;
        trn.trn_reof_n     = 1'b1;
        trn.trn_rsrc_rdy_n = 1'b1;
        trn.trn_rsrc_dsc_n = 1'b1;
        trn.trn_rerrfwd_n  = 1'b1;
        test_reset();
        test_single();
        test_split();
        test_mismatch();
        test_idle_consume();
        test_error();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
